// File: rtl/wave_freq_meter.sv
// Frequency meter for one reconstructed DA channel: hysteresis squaring of the
// FIFO sample stream, rising-crossing count over a fixed gate, saturated Hz output.
module wave_freq_meter #(
   parameter int unsigned GATE_CYCLES = 1024000,
   parameter int unsigned MID         = 128,
   parameter int unsigned HYST        = 8,
   parameter int unsigned FREQ_W      = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [7:0]        sample,
   output logic [FREQ_W-1:0] freq,
   output logic              freq_valid,
   output logic              freq_ovf
);

   localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam int unsigned       EDGE_W    = 21;
   localparam logic [EDGE_W-1:0] EDGE_MAX  = '1;

   // Thresholds live in 9 bits; a threshold outside 0..255 can never be met.
   localparam int unsigned HI_SUM = MID + HYST;
   localparam bit          HI_OK  = (HI_SUM <= 255);
   localparam bit          LO_OK  = (MID >= HYST);
   localparam logic [8:0]  HI_THR = 9'(HI_SUM);
   localparam logic [8:0]  LO_THR = LO_OK ? 9'(MID - HYST) : '0;

   localparam bit                FREQ_WIDE = (FREQ_W >= EDGE_W);
   localparam logic [EDGE_W-1:0] FREQ_MAX  = FREQ_WIDE ? '1 : EDGE_W'((64'd1 << FREQ_W) - 64'd1);

   typedef enum logic [1:0] {S_UNARMED, S_LOW, S_HIGH} state_e;

   state_e              state_q, state_d;
   logic [GATE_W-1:0]   gate_q, gate_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic [FREQ_W-1:0]   freq_q, freq_d;
   logic                ovf_q, ovf_d;
   logic                fv_q;

   logic [8:0]          samp9;
   logic                at_hi, at_lo;
   logic                edge_pulse;
   logic                gate_end;
   logic [EDGE_W-1:0]   edge_total;

   assign samp9 = {1'b0, sample};
   assign at_hi = HI_OK && (samp9 >= HI_THR);
   assign at_lo = LO_OK && (samp9 <= LO_THR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_UNARMED;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!sample_valid) begin
         state_d = S_UNARMED;
      end else begin
         unique case (state_q)
            S_UNARMED: if (at_hi) state_d = S_HIGH; else if (at_lo) state_d = S_LOW;
            S_LOW:     if (at_hi) state_d = S_HIGH;
            S_HIGH:    if (at_lo) state_d = S_LOW;
            default:   state_d = S_UNARMED;
         endcase
      end
   end

   always_comb begin
      edge_pulse = sample_valid && (state_q == S_LOW) && at_hi;
   end

   // The closing cycle's own edge is folded in before latching the result.
   always_comb begin
      gate_end   = (gate_q == GATE_LAST);
      gate_d     = gate_end ? '0 : gate_q + GATE_W'(1);
      edge_total = (edge_pulse && (edge_q != EDGE_MAX)) ? edge_q + EDGE_W'(1) : edge_q;
      edge_d     = gate_end ? '0 : edge_total;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      if (gate_end) begin
         ovf_d  = !FREQ_WIDE && (edge_total > FREQ_MAX);
         freq_d = ovf_d ? '1 : FREQ_W'(edge_total);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_q <= '0;
         edge_q <= '0;
         freq_q <= '0;
         ovf_q  <= 1'b0;
         fv_q   <= 1'b0;
      end else begin
         gate_q <= gate_d;
         edge_q <= edge_d;
         freq_q <= freq_d;
         ovf_q  <= ovf_d;
         fv_q   <= gate_end;
      end
   end

   assign freq       = freq_q;
   assign freq_valid = fv_q;
   assign freq_ovf   = ovf_q;

endmodule

// File: tb/tb_wave_freq_meter.sv
// Directed bench for wave_freq_meter: a wide-output and a 4-bit-output instance
// share one stimulus stream; each gate's report is checked against hand counts.
module tb_wave_freq_meter;

   localparam int GATE = 1000;

   localparam int M_SQ100 = 0;
   localparam int M_BAND  = 1;
   localparam int M_SMALL = 2;
   localparam int M_SINE  = 3;
   localparam int M_GAP20 = 4;
   localparam int M_NONE  = 5;
   localparam int M_ALT   = 6;
   localparam int M_P99   = 7;
   localparam int M_P50   = 8;
   localparam int M_P0    = 9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [7:0]  sample = 8'd0;
   logic [12:0] freq13;
   logic        fv13, ovf13;
   logic [3:0]  freq4;
   logic        fv4, ovf4;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wave_freq_meter #(.GATE_CYCLES(GATE), .MID(128), .HYST(8), .FREQ_W(13)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
      .freq(freq13), .freq_valid(fv13), .freq_ovf(ovf13));

   wave_freq_meter #(.GATE_CYCLES(GATE), .MID(128), .HYST(8), .FREQ_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
      .freq(freq4), .freq_valid(fv4), .freq_ovf(ovf4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sine20(input int k);
      case (k)
         0: return 8'd128;   1: return 8'd159;   2: return 8'd187;   3: return 8'd209;
         4: return 8'd223;   5: return 8'd228;   6: return 8'd223;   7: return 8'd209;
         8: return 8'd187;   9: return 8'd159;  10: return 8'd128;  11: return 8'd97;
        12: return 8'd69;   13: return 8'd47;   14: return 8'd33;   15: return 8'd28;
        16: return 8'd33;   17: return 8'd47;   18: return 8'd69;   default: return 8'd97;
      endcase
   endfunction

   function automatic logic [7:0] small8(input int k);
      case (k)
         0: return 8'd128; 1: return 8'd130; 2: return 8'd132; 3: return 8'd130;
         4: return 8'd128; 5: return 8'd126; 6: return 8'd124; default: return 8'd126;
      endcase
   endfunction

   // Returns {valid, sample} for gate-local cycle c.
   function automatic logic [8:0] stim(input int mode, input int c);
      int p;
      p = c % 100;
      case (mode)
         M_SQ100: return {1'b1, (p < 50) ? 8'd40 : 8'd220};
         M_BAND: begin
            if (p == 0)       return {1'b1, 8'd121};
            else if (p == 50) return {1'b1, 8'd135};
            else if (p < 50)  return {1'b1, 8'd120};
            else              return {1'b1, 8'd136};
         end
         M_SMALL: return {c != 0, small8(c % 8)};
         M_SINE:  return {1'b1, sine20(c % 20)};
         M_GAP20: return {p != 15, ((c % 20) < 10) ? 8'd40 : 8'd220};
         M_NONE:  return {1'b0, ((c % 2) == 1) ? 8'd220 : 8'd40};
         M_ALT:   return {1'b1, ((c % 2) == 1) ? 8'd255 : 8'd0};
         M_P99:   return {1'b1, (p == 99) ? 8'd220 : 8'd40};
         M_P50:   return {1'b1, (p == 50) ? 8'd220 : 8'd40};
         default: return {1'b1, (p == 0) ? 8'd220 : 8'd40};
      endcase
   endfunction

   // Entered at a negedge; drives cycle 0 there and each later cycle at the next negedge.
   task automatic run_gate(input int mode, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         if (c != 0) @(negedge clk);
         if (c == 1)        chk("fv_low_after_start", 32'(fv13), 32'd0);
         if (c == GATE - 1) chk("fv_low_before_end", 32'(fv13), 32'd0);
         {sample_valid, sample} = stim(mode, c);
      end
   endtask

   task automatic end_gate(input string tag, input int e13, input int e4, input bit eovf4);
      @(negedge clk);
      chk({tag, "_fv13"},   32'(fv13),   32'd1);
      chk({tag, "_freq13"}, 32'(freq13), 32'(e13));
      chk({tag, "_ovf13"},  32'(ovf13),  32'd0);
      chk({tag, "_fv4"},    32'(fv4),    32'd1);
      chk({tag, "_freq4"},  32'(freq4),  32'(e4));
      chk({tag, "_ovf4"},   32'(ovf4),   32'(eovf4));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_freq13", 32'(freq13), 32'd0);
      chk("rst_fv13",   32'(fv13),   32'd0);
      chk("rst_ovf13",  32'(ovf13),  32'd0);
      chk("rst_freq4",  32'(freq4),  32'd0);
      rst_n = 1'b1;

      run_gate(M_SQ100, GATE); end_gate("sq100",   10, 10, 1'b0);
      run_gate(M_BAND,  GATE); end_gate("band",    10, 10, 1'b0);
      run_gate(M_SMALL, GATE); end_gate("small",    0,  0, 1'b0);
      run_gate(M_SINE,  GATE); end_gate("sine_1",  49, 15, 1'b1);
      run_gate(M_SINE,  GATE); end_gate("sine_2",  50, 15, 1'b1);
      run_gate(M_GAP20, GATE); end_gate("gap20",   50, 15, 1'b1);
      run_gate(M_NONE,  GATE); end_gate("novalid",  0,  0, 1'b0);
      run_gate(M_ALT,   GATE); end_gate("alt",    500, 15, 1'b1);
      run_gate(M_SQ100, GATE); end_gate("sq100_b", 10, 10, 1'b0);
      run_gate(M_P99,   GATE); end_gate("edge_last",  10, 10, 1'b0);
      run_gate(M_P50,   GATE); end_gate("mid_pulse",  10, 10, 1'b0);
      run_gate(M_P0,    GATE); end_gate("edge_first", 10, 10, 1'b0);

      // Reset partway through a gate: outputs clear at once, partial gate is dropped.
      run_gate(M_SQ100, 600);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_freq13", 32'(freq13), 32'd0);
      chk("midrst_fv13",   32'(fv13),   32'd0);
      chk("midrst_ovf13",  32'(ovf13),  32'd0);
      chk("midrst_freq4",  32'(freq4),  32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_gate(M_SQ100, GATE); end_gate("after_rst", 10, 10, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
